fp_div_issuer: RTL and testbench

FP_DIV_ISSUER -- requirements
Module: fp_div_issuer

---
 rtl/fp_div_issuer.sv | 181 ++++++++++++++++++
 tb/tb_fp_div_issuer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_issuer.sv
// ============================================================================
// Module   : fp_div_issuer
// Brief    : Issues one FP division at a time to an external divider, with
//            timeout, software cancel and a held response.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_div_issuer #(
   parameter int exp_width  = 8,
   parameter int mant_width = 24,
   parameter int TIMEOUT    = 64,
   localparam int total_width = exp_width + mant_width
) (
   input  logic                   clk,
   input  logic                   rst_l,
   // upstream request
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [total_width-1:0] req_a,
   input  logic [total_width-1:0] req_b,
   input  logic [2:0]             req_rm,
   input  logic                   sw_cancel,
   // divider issue side
   output logic                   div_in_valid,
   input  logic                   div_in_ready,
   output logic [total_width-1:0] div_a,
   output logic [total_width-1:0] div_b,
   output logic [2:0]             div_round_mode,
   output logic                   div_cancel,
   // divider result side
   input  logic                   div_out_valid,
   input  logic [total_width-1:0] div_out,
   input  logic [4:0]             div_exceptions,
   // downstream response
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [total_width-1:0] rsp_data,
   output logic [4:0]             rsp_exc,
   output logic                   rsp_timeout,
   // statistics
   output logic [15:0]            issued_cnt,
   output logic [7:0]             timeout_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   // Last WAIT cycle index: the divider gets exactly TIMEOUT cycles to answer.
   localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

   state_t                 state_q,       state_d;
   logic [total_width-1:0] a_q,           a_d;
   logic [total_width-1:0] b_q,           b_d;
   logic [2:0]             rm_q,          rm_d;
   logic [7:0]             wait_cnt_q,    wait_cnt_d;
   logic [15:0]            issued_cnt_q,  issued_cnt_d;
   logic [7:0]             timeout_cnt_q, timeout_cnt_d;
   logic [total_width-1:0] rsp_data_q,    rsp_data_d;
   logic [4:0]             rsp_exc_q,     rsp_exc_d;
   logic                   rsp_timeout_q, rsp_timeout_d;
   logic                   div_cancel_q,  div_cancel_d;

   always_comb begin
      state_d       = state_q;
      a_d           = a_q;
      b_d           = b_q;
      rm_d          = rm_q;
      wait_cnt_d    = wait_cnt_q;
      issued_cnt_d  = issued_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
      rsp_data_d    = rsp_data_q;
      rsp_exc_d     = rsp_exc_q;
      rsp_timeout_d = rsp_timeout_q;
      div_cancel_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               rm_d    = req_rm;
               state_d = S_ISSUE;
            end
         end

         S_ISSUE: begin
            // Cancel takes priority over a concurrent divider accept.
            if (sw_cancel) begin
               state_d = S_IDLE;
            end else if (div_in_ready) begin
               wait_cnt_d   = 8'd0;
               issued_cnt_d = issued_cnt_q + 16'd1;
               state_d      = S_WAIT;
            end
         end

         S_WAIT: begin
            if (sw_cancel) begin
               div_cancel_d = 1'b1;
               state_d      = S_IDLE;
            end else if (div_out_valid) begin
               rsp_data_d    = div_out;
               rsp_exc_d     = div_exceptions;
               rsp_timeout_d = 1'b0;
               state_d       = S_HOLD;
            end else if (wait_cnt_q == c_wait_last) begin
               div_cancel_d  = 1'b1;
               rsp_data_d    = '0;
               rsp_exc_d     = 5'd0;
               rsp_timeout_d = 1'b1;
               if (timeout_cnt_q != 8'hFF) begin
                  timeout_cnt_d = timeout_cnt_q + 8'd1;
               end
               state_d = S_HOLD;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end

         S_HOLD: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q       <= S_IDLE;
         a_q           <= '0;
         b_q           <= '0;
         rm_q          <= 3'd0;
         wait_cnt_q    <= 8'd0;
         issued_cnt_q  <= 16'd0;
         timeout_cnt_q <= 8'd0;
         rsp_data_q    <= '0;
         rsp_exc_q     <= 5'd0;
         rsp_timeout_q <= 1'b0;
         div_cancel_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         b_q           <= b_d;
         rm_q          <= rm_d;
         wait_cnt_q    <= wait_cnt_d;
         issued_cnt_q  <= issued_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
         rsp_data_q    <= rsp_data_d;
         rsp_exc_q     <= rsp_exc_d;
         rsp_timeout_q <= rsp_timeout_d;
         div_cancel_q  <= div_cancel_d;
      end
   end

   // Handshake outputs come straight from the state register.
   assign req_ready      = (state_q == S_IDLE);
   assign div_in_valid   = (state_q == S_ISSUE);
   assign rsp_valid      = (state_q == S_HOLD);
   assign div_cancel     = div_cancel_q;
   assign div_a          = a_q;
   assign div_b          = b_q;
   assign div_round_mode = rm_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_exc        = rsp_exc_q;
   assign rsp_timeout    = rsp_timeout_q;
   assign issued_cnt     = issued_cnt_q;
   assign timeout_cnt    = timeout_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_div_issuer.sv
// ============================================================================
// Module   : tb_fp_div_issuer
// Brief    : Scoreboard bench for fp_div_issuer with a scripted divider model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fp_div_issuer;

   localparam int EW = 8;
   localparam int MW = 24;
   localparam int TW = EW + MW;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst_l = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [TW-1:0] req_a = '0;
   logic [TW-1:0] req_b = '0;
   logic [2:0]    req_rm = 3'd0;
   logic          sw_cancel = 1'b0;
   logic          div_in_valid;
   logic          div_in_ready = 1'b0;
   logic [TW-1:0] div_a;
   logic [TW-1:0] div_b;
   logic [2:0]    div_round_mode;
   logic          div_cancel;
   logic          div_out_valid = 1'b0;
   logic [TW-1:0] div_out = '0;
   logic [4:0]    div_exceptions = 5'd0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [TW-1:0] rsp_data;
   logic [4:0]    rsp_exc;
   logic          rsp_timeout;
   logic [15:0]   issued_cnt;
   logic [7:0]    timeout_cnt;

   fp_div_issuer #(
      .exp_width (EW),
      .mant_width(MW),
      .TIMEOUT   (TO)
   ) dut (
      .clk           (clk),
      .rst_l         (rst_l),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_rm        (req_rm),
      .sw_cancel     (sw_cancel),
      .div_in_valid  (div_in_valid),
      .div_in_ready  (div_in_ready),
      .div_a         (div_a),
      .div_b         (div_b),
      .div_round_mode(div_round_mode),
      .div_cancel    (div_cancel),
      .div_out_valid (div_out_valid),
      .div_out       (div_out),
      .div_exceptions(div_exceptions),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_exc       (rsp_exc),
      .rsp_timeout   (rsp_timeout),
      .issued_cnt    (issued_cnt),
      .timeout_cnt   (timeout_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected responses {data, exc, timeout}, in issue order.
   logic [TW+5:0] exp_q[$];
   int exp_issued = 0;
   int exp_to     = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Response monitor: pops the scoreboard on each completed response handshake
   // and checks the response stays frozen while back-pressured.
   logic          mon_held = 1'b0;
   logic [TW+5:0] mon_held_v = '0;
   logic [TW+5:0] mon_e;

   always @(negedge clk) begin
      if (div_cancel) chk("cancel_with_issue", {63'd0, div_in_valid}, 64'd0);
      if (rsp_valid) begin
         if (mon_held) chk("rsp_stable", {26'd0, rsp_data, rsp_exc, rsp_timeout}, {26'd0, mon_held_v});
         if (rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rsp_unexpected: got %0h expected none", {rsp_data, rsp_exc, rsp_timeout});
            end else begin
               mon_e = exp_q.pop_front();
               chk("rsp", {26'd0, rsp_data, rsp_exc, rsp_timeout}, {26'd0, mon_e});
            end
            mon_held = 1'b0;
         end else begin
            mon_held   = 1'b1;
            mon_held_v = {rsp_data, rsp_exc, rsp_timeout};
         end
      end else begin
         mon_held = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int b = 0;
      while (!req_ready && b < 20) begin
         step();
         b++;
      end
      chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
   endtask

   task automatic take_rsp(input int rsp_dly);
      chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
      for (int i = 0; i < rsp_dly; i++) begin
         // Stray divider pulses and cancels in HOLD must be ignored.
         div_out_valid  = (i == 0);
         div_out        = $urandom;
         div_exceptions = 5'($urandom);
         sw_cancel      = (i == 1);
         chk("hold_no_req_ready", {63'd0, req_ready}, 64'd0);
         step();
      end
      div_out_valid = 1'b0;
      sw_cancel     = 1'b0;
      rsp_ready     = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("idle_after_rsp", {63'd0, req_ready}, 64'd1);
   endtask

   // kind: 0 result, 1 no result (timeout), 2 cancel in ISSUE, 3 cancel in WAIT
   task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic [2:0] rm,
                         input int kind, input int rdy_dly, input int lat,
                         input logic [TW-1:0] res, input logic [4:0] exc, input int rsp_dly);
      int k;
      wait_idle();
      req_a = a; req_b = b; req_rm = rm; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      req_a = $urandom; req_b = $urandom; req_rm = 3'($urandom);
      chk("issue_valid", {63'd0, div_in_valid}, 64'd1);
      chk("div_a", {32'd0, div_a}, {32'd0, a});
      chk("div_b", {32'd0, div_b}, {32'd0, b});
      chk("div_rm", {61'd0, div_round_mode}, {61'd0, rm});
      chk("issue_no_req_ready", {63'd0, req_ready}, 64'd0);

      if (kind == 2) begin
         sw_cancel = 1'b1; div_in_ready = 1'b1;
         step();
         sw_cancel = 1'b0; div_in_ready = 1'b0;
         chk("isscancel_idle", {63'd0, req_ready}, 64'd1);
         chk("isscancel_no_issue", {63'd0, div_in_valid}, 64'd0);
         chk("isscancel_no_pulse", {63'd0, div_cancel}, 64'd0);
         chk("isscancel_cnt", {48'd0, issued_cnt}, 64'(exp_issued));
         return;
      end

      for (int i = 0; i < rdy_dly; i++) begin
         step();
         chk("issue_hold_valid", {63'd0, div_in_valid}, 64'd1);
         chk("issue_hold_a", {32'd0, div_a}, {32'd0, a});
         chk("issue_hold_b", {32'd0, div_b}, {32'd0, b});
         chk("issue_hold_ready", {63'd0, req_ready}, 64'd0);
      end
      div_in_ready = 1'b1;
      step();
      div_in_ready = 1'b0;
      exp_issued = (exp_issued + 1) % 65536;
      chk("issued_cnt", {48'd0, issued_cnt}, 64'(exp_issued));
      chk("issue_dropped", {63'd0, div_in_valid}, 64'd0);

      if (kind == 1) begin
         exp_q.push_back({{TW{1'b0}}, 5'd0, 1'b1});
         exp_to = (exp_to < 255) ? exp_to + 1 : 255;
         k = 0;
         while (!div_cancel && k < TO + 4) begin
            step();
            k++;
         end
         chk("timeout_delay", 64'(k), 64'(TO));
         chk("timeout_cnt_upd", {56'd0, timeout_cnt}, 64'(exp_to));
         step();
         chk("cancel_one_cycle", {63'd0, div_cancel}, 64'd0);
         take_rsp(rsp_dly);
      end else begin
         for (int i = 0; i < lat - 1; i++) step();
         div_out_valid = 1'b1; div_out = res; div_exceptions = exc;
         sw_cancel = (kind == 3);
         if (kind != 3) exp_q.push_back({res, exc, 1'b0});
         step();
         div_out_valid = 1'b0; sw_cancel = 1'b0;
         div_out = $urandom; div_exceptions = 5'($urandom);
         if (kind == 3) begin
            chk("swc_pulse", {63'd0, div_cancel}, 64'd1);
            chk("swc_req_ready", {63'd0, req_ready}, 64'd1);
            chk("swc_no_rsp", {63'd0, rsp_valid}, 64'd0);
            step();
            chk("swc_pulse_end", {63'd0, div_cancel}, 64'd0);
         end else begin
            chk("result_no_cancel", {63'd0, div_cancel}, 64'd0);
            take_rsp(rsp_dly);
         end
      end
      chk("timeout_cnt", {56'd0, timeout_cnt}, 64'(exp_to));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_valid"},  {63'd0, div_in_valid}, 64'd0);
      chk({tag, "_cancel"},    {63'd0, div_cancel}, 64'd0);
      chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
      chk({tag, "_rsp"},       {26'd0, rsp_data, rsp_exc, rsp_timeout}, 64'd0);
      chk({tag, "_opnd"},      {div_a, div_b}, 64'd0);
      chk({tag, "_cnts"},      {40'd0, issued_cnt, timeout_cnt}, 64'd0);
      chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
   endtask

   initial begin
      int r;
      #12;
      chk_reset_outputs("reset");
      step();
      rst_l = 1'b1;
      step();

      // Worked examples
      run_op(32'h40C00000, 32'h40000000, 3'b000, 0, 0, 5, 32'h40400000, 5'b00000, 2);
      chk("first_issued", {48'd0, issued_cnt}, 64'd1);
      run_op(32'hC1400000, 32'h40800000, 3'b001, 0, 1, 3, 32'hC0400000, 5'b00000, 0);
      run_op(32'h3F800000, 32'h00000000, 3'b010, 0, 0, 2, 32'h7F800000, 5'b01000, 1);
      run_op(32'h3F800000, 32'h40000000, 3'b000, 1, 0, 0, '0, 5'd0, 1);
      chk("first_timeout", {56'd0, timeout_cnt}, 64'd1);
      run_op(32'h12345678, 32'h9ABCDEF0, 3'b100, 0, 7, 4, 32'h0BADF00D, 5'b00001, 10);
      // Result on the last permitted cycle beats the timeout.
      run_op(32'h41000000, 32'h40000000, 3'b000, 0, 0, TO, 32'h40800000, 5'b00000, 0);
      run_op(32'h41000000, 32'h40000000, 3'b011, 2, 0, 0, '0, 5'd0, 0);
      run_op(32'h41000000, 32'h40000000, 3'b011, 3, 0, 6, 32'h40800000, 5'd0, 0);
      run_op(32'h41000000, 32'h40000000, 3'b011, 3, 2, TO, 32'h40800000, 5'd0, 0);

      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         run_op($urandom, $urandom, 3'($urandom),
                (r < 7) ? 0 : r - 6,
                $urandom_range(0, 3), $urandom_range(1, TO),
                $urandom, 5'($urandom), $urandom_range(0, 3));
      end

      for (int n = 0; n < 300; n++)
         run_op($urandom, $urandom, 3'($urandom), 1, 0, 0, '0, 5'd0, 0);
      chk("timeout_saturated", {56'd0, timeout_cnt}, 64'hFF);

      // Reset while an operation sits in WAIT.
      wait_idle();
      req_a = 32'h40C00000; req_b = 32'h40000000; req_valid = 1'b1;
      step();
      req_valid = 1'b0; div_in_ready = 1'b1;
      step();
      div_in_ready = 1'b0;
      step();
      #2 rst_l = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      step();
      rst_l = 1'b1;
      exp_issued = 0;
      exp_to     = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_reset_no_rsp", {62'd0, rsp_valid, div_cancel}, 64'd0);
      end
      run_op(32'h40C00000, 32'h40000000, 3'b000, 0, 0, 5, 32'h40400000, 5'b00000, 0);
      chk("post_reset_issued", {48'd0, issued_cnt}, 64'd1);

      repeat (3) step();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

`default_nettype wire
